// File: rtl/uart_mmio_pkg.sv
// Shared register map, STAT bit positions and FSM types for the UART MMIO block
// and its hardware initiator.
package uart_mmio_pkg;

    localparam logic [1:0] ADDR_CTRL = 2'd0;
    localparam logic [1:0] ADDR_STAT = 2'd1;
    localparam logic [1:0] ADDR_TX   = 2'd2;
    localparam logic [1:0] ADDR_RX   = 2'd3;

    localparam int STAT_TX_RDY   = 1;
    localparam int STAT_RX_AVAIL = 0;

    typedef enum logic [1:0] {
        S_POLL  = 2'd0,
        S_WRITE = 2'd1,
        S_GUARD = 2'd2,
        S_READ  = 2'd3
    } state_t;

    typedef enum logic {
        GRANT_TX = 1'b0,
        GRANT_RX = 1'b1
    } grant_t;

endpackage

// File: rtl/uart_mmio_initiator_byte_hold_reg.sv
// One-entry valid/ready byte register: loads on handshake, empties on an
// external clear strobe.
module byte_hold_reg (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] load_byte,
    input  logic       load_valid,
    output logic       load_ready,
    input  logic       clear,
    output logic [7:0] hold_byte,
    output logic       hold_full
);

    logic       full_r;
    logic [7:0] byte_r;

    // Occupancy and data; load and clear never coincide since clear implies full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_r <= 1'b0;
            byte_r <= 8'h00;
        end else if (load_valid && !full_r) begin
            full_r <= 1'b1;
            byte_r <= load_byte;
        end else if (clear) begin
            full_r <= 1'b0;
        end
    end

    assign load_ready = !full_r;
    assign hold_byte  = byte_r;
    assign hold_full  = full_r;

endmodule

// File: rtl/uart_mmio_initiator.sv
// Polls the UART MMIO slave's STAT register and turns TX/RX byte streams into
// single-cycle register writes and reads, arbitrating round-robin on contention.
module uart_mmio_initiator
    import uart_mmio_pkg::*;
#(
    parameter int WR_GUARD = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_byte,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic [1:0] mmio_addr,
    output logic       mmio_wr_en,
    output logic [7:0] mmio_wr_data,
    input  logic [7:0] mmio_rd_data
);

    localparam int GUARD_W = $clog2(WR_GUARD);
    localparam logic [GUARD_W-1:0] GUARD_LAST = GUARD_W'(WR_GUARD - 1);

    state_t               state_r;
    grant_t               last_grant_r;
    logic [GUARD_W-1:0]   guard_cnt_r;
    logic [7:0]           tx_hold_s;
    logic                 tx_full_s;
    logic                 tx_clear_s;
    logic                 tx_elig_s;
    logic                 rx_elig_s;
    logic                 tx_win_s;

    byte_hold_reg u_tx_hold (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_byte  (tx_byte),
        .load_valid (tx_valid),
        .load_ready (tx_ready),
        .clear      (tx_clear_s),
        .hold_byte  (tx_hold_s),
        .hold_full  (tx_full_s)
    );

    // Eligibility is only meaningful in S_POLL, where the address is STAT.
    always_comb begin
        tx_clear_s = 1'b0;
        tx_elig_s  = 1'b0;
        rx_elig_s  = 1'b0;
        tx_win_s   = 1'b0;
        if (state_r == S_WRITE) begin
            tx_clear_s = 1'b1;
        end else begin
            tx_clear_s = 1'b0;
        end
        tx_elig_s = tx_full_s && mmio_rd_data[STAT_TX_RDY];
        rx_elig_s = mmio_rd_data[STAT_RX_AVAIL] && !rx_valid;
        tx_win_s  = tx_elig_s && (!rx_elig_s || (last_grant_r == GRANT_RX));
    end

    // Access sequencer with Moore outputs registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= S_POLL;
            last_grant_r <= GRANT_RX;
            guard_cnt_r  <= '0;
            mmio_addr    <= ADDR_STAT;
            mmio_wr_en   <= 1'b0;
            mmio_wr_data <= 8'h00;
        end else begin
            case (state_r)
                S_POLL: begin
                    if (tx_win_s) begin
                        state_r      <= S_WRITE;
                        mmio_addr    <= ADDR_TX;
                        mmio_wr_en   <= 1'b1;
                        mmio_wr_data <= tx_hold_s;
                    end else if (rx_elig_s) begin
                        state_r   <= S_READ;
                        mmio_addr <= ADDR_RX;
                    end
                end
                S_WRITE: begin
                    state_r      <= S_GUARD;
                    mmio_addr    <= ADDR_STAT;
                    mmio_wr_en   <= 1'b0;
                    guard_cnt_r  <= '0;
                    last_grant_r <= GRANT_TX;
                end
                S_GUARD: begin
                    if (guard_cnt_r == GUARD_LAST) begin
                        state_r     <= S_POLL;
                        guard_cnt_r <= '0;
                    end else begin
                        guard_cnt_r <= guard_cnt_r + 1'b1;
                    end
                end
                S_READ: begin
                    state_r      <= S_POLL;
                    mmio_addr    <= ADDR_STAT;
                    last_grant_r <= GRANT_RX;
                end
                default: begin
                    state_r    <= S_POLL;
                    mmio_addr  <= ADDR_STAT;
                    mmio_wr_en <= 1'b0;
                end
            endcase
        end
    end

    // RX holding register: filled by the read cycle, drained by the consumer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_valid <= 1'b0;
            rx_byte  <= 8'h00;
        end else if (state_r == S_READ) begin
            rx_valid <= 1'b1;
            rx_byte  <= mmio_rd_data;
        end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_mmio_initiator.sv
// Directed bench with a transaction-level model of the initiator and a simple
// combinational slave whose STAT/RX values are driven by the stimulus.
module tb_uart_mmio_initiator;

    localparam int WR_GUARD = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tx_byte = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic [1:0] mmio_addr;
    logic       mmio_wr_en;
    logic [7:0] mmio_wr_data;
    logic [7:0] mmio_rd_data;

    logic [7:0] stat_v = 8'h02;
    logic [7:0] rx_data_v = 8'h00;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int writes = 0;
    int reads = 0;
    int last_wr_cyc = -1000;
    logic [7:0] last_wr_data = 8'h00;
    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];
    int glog[$];
    bit have_prev = 1'b0;
    logic prev_rv, prev_rr;
    logic [7:0] prev_rb;

    uart_mmio_initiator #(.WR_GUARD(WR_GUARD)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tx_byte      (tx_byte),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .rx_byte      (rx_byte),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .mmio_addr    (mmio_addr),
        .mmio_wr_en   (mmio_wr_en),
        .mmio_wr_data (mmio_wr_data),
        .mmio_rd_data (mmio_rd_data)
    );

    always #5 clk = ~clk;

    // Slave read mux: STAT and RX are bench-controlled, others read zero.
    always_comb begin
        case (mmio_addr)
            2'd1:    mmio_rd_data = stat_v;
            2'd3:    mmio_rd_data = rx_data_v;
            default: mmio_rd_data = 8'h00;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction model and per-cycle rule checks, sampled mid-cycle.
    always @(negedge clk) begin
        logic [7:0] e;
        cyc++;
        if (!rst_n) begin
            tx_q.delete();
            rx_q.delete();
            have_prev   = 1'b0;
            last_wr_cyc = -1000;
        end else begin
            chk("tx_ready_vs_model", tx_ready, tx_q.size() == 0);
            chk("rx_valid_vs_model", rx_valid, rx_q.size() != 0);
            chk("wr_en_iff_addr_tx", mmio_wr_en, mmio_addr == 2'd2);
            chk("addr_not_ctrl", mmio_addr != 2'd0, 1);
            if (have_prev && prev_rv && !prev_rr) begin
                chk("rx_hold_valid", rx_valid, 1);
                chk("rx_hold_byte", rx_byte, prev_rb);
            end
            if (mmio_addr == 2'd3) begin
                chk("rx_read_when_full", rx_q.size(), 0);
                rx_q.push_back(rx_data_v);
                reads++;
                glog.push_back(1);
            end
            if (mmio_wr_en) begin
                chk("write_expected", tx_q.size() != 0, 1);
                if (tx_q.size() != 0) begin
                    e = tx_q.pop_front();
                    chk("wr_data", mmio_wr_data, e);
                end
                chk("wr_gap", (cyc - last_wr_cyc) >= WR_GUARD + 2, 1);
                last_wr_cyc  = cyc;
                last_wr_data = mmio_wr_data;
                writes++;
                glog.push_back(0);
            end
            if (rx_valid && rx_ready && rx_q.size() != 0) begin
                e = rx_q.pop_front();
                chk("rx_byte", rx_byte, e);
            end
            if (tx_valid && tx_ready) tx_q.push_back(tx_byte);
            have_prev = 1'b1;
            prev_rv   = rx_valid;
            prev_rr   = rx_ready;
            prev_rb   = rx_byte;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic drive_tx(input logic [7:0] b);
        bit done;
        done = 1'b0;
        @(posedge clk);
        #1;
        tx_byte  = b;
        tx_valid = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (tx_ready) done = 1'b1;
        end
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        chk("tx_accept_timeout", done, 1);
    endtask

    task automatic consume_rx();
        @(posedge clk);
        #1;
        rx_ready = 1'b1;
        @(posedge clk);
        #1;
        rx_ready = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int n0;
        bit seen;

        // Reset state with STAT showing tx_rdy.
        stat_v = 8'h02;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        chk("rst_addr", mmio_addr, 2'd1);
        chk("rst_wr_en", mmio_wr_en, 1'b0);
        chk("rst_wr_data", mmio_wr_data, 8'h00);
        chk("rst_tx_ready", tx_ready, 1'b1);
        chk("rst_rx_valid", rx_valid, 1'b0);
        chk("rst_rx_byte", rx_byte, 8'h00);

        // Single TX byte: write one cycle after acceptance, then guard at STAT.
        n0 = writes;
        drive_tx(8'h41);
        tick();
        chk("tx1_no_write_yet", mmio_wr_en, 1'b0);
        chk("tx1_ready_low", tx_ready, 1'b0);
        tick();
        chk("tx1_wr_en", mmio_wr_en, 1'b1);
        chk("tx1_addr", mmio_addr, 2'd2);
        chk("tx1_data", mmio_wr_data, 8'h41);
        for (int i = 0; i < WR_GUARD; i++) begin
            tick();
            chk("tx1_guard_addr", mmio_addr, 2'd1);
            chk("tx1_guard_wr_en", mmio_wr_en, 1'b0);
            chk("tx1_guard_tx_ready", tx_ready, 1'b1);
        end
        repeat (5) tick();
        chk("tx1_write_count", writes - n0, 1);

        // TX backpressure: no write while tx_rdy is low.
        stat_v = 8'h00;
        n0 = writes;
        drive_tx(8'h55);
        repeat (50) tick();
        chk("bp_no_write", writes - n0, 0);
        chk("bp_tx_ready", tx_ready, 1'b0);
        stat_v = 8'h02;
        repeat (10) tick();
        chk("bp_one_write", writes - n0, 1);
        chk("bp_data", last_wr_data, 8'h55);

        // RX with consumer stall.
        rx_ready  = 1'b0;
        rx_data_v = 8'hA5;
        stat_v    = 8'h01;
        n0 = reads;
        repeat (10) tick();
        chk("rx_one_read", reads - n0, 1);
        chk("rx_valid_set", rx_valid, 1'b1);
        chk("rx_byte_a5", rx_byte, 8'hA5);
        rx_data_v = 8'h3C;
        repeat (10) tick();
        chk("rx_no_read_when_full", reads - n0, 1);
        chk("rx_byte_still_a5", rx_byte, 8'hA5);
        consume_rx();
        repeat (5) tick();
        chk("rx_second_read", reads - n0, 2);
        chk("rx_byte_3c", rx_byte, 8'h3C);
        stat_v = 8'h00;
        consume_rx();
        tick();
        chk("rx_drained", rx_valid, 1'b0);

        // Contention from reset: TX first, then strict alternation.
        stat_v = 8'h00;
        do_reset();
        rx_ready = 1'b1;
        n0 = writes;
        drive_tx(8'h10);
        stat_v = 8'h03;
        glog.delete();
        drive_tx(8'h11);
        drive_tx(8'h12);
        drive_tx(8'h13);
        repeat (20) tick();
        stat_v = 8'h00;
        repeat (5) tick();
        rx_ready = 1'b0;
        chk("cont_writes", writes - n0, 4);
        chk("cont_grant_count", glog.size() >= 7, 1);
        for (int i = 0; i < 7 && i < glog.size(); i++) begin
            chk($sformatf("cont_grant_%0d", i), glog[i], i % 2);
        end
        tick();

        // Reset during a write cuts the strobe and drops the byte.
        stat_v = 8'h00;
        drive_tx(8'h99);
        stat_v = 8'h02;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (mmio_wr_en) seen = 1'b1;
        end
        chk("mid_write_seen", seen, 1);
        chk("mid_write_data", mmio_wr_data, 8'h99);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_wr_en", mmio_wr_en, 1'b0);
        chk("mid_rst_addr", mmio_addr, 2'd1);
        chk("mid_rst_tx_ready", tx_ready, 1'b1);
        n0 = writes;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (30) tick();
        chk("mid_rst_no_resend", writes - n0, 0);
        chk("mid_rst_idle_ready", tx_ready, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_mmio_initiator.md
# uart_mmio_initiator

Hardware bus initiator for the UART MMIO register block. It turns a byte-stream transmit interface and a byte-stream receive interface into polled register accesses on the UART's 2-bit MMIO port. It sits between a hardware producer/consumer (console logger, loopback test engine) and the UART MMIO slave, and takes the place of software polling.

## Interface
Parameters:
- `WR_GUARD`, 2: cycles the FSM waits after a TX write before it polls STAT again. Minimum 2; covers the slave's valid/ready turnaround.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: reset, asynchronous and active-low.
- `tx_byte` in 8: byte to transmit.
- `tx_valid` in 1: `tx_byte` is valid.
- `tx_ready` out 1: the transmit holding register is empty.
- `rx_byte` out 8: received byte.
- `rx_valid` out 1: `rx_byte` is valid.
- `rx_ready` in 1: the consumer accepts `rx_byte`.
- `mmio_addr` out 2: register address. CTRL=0, STAT=1, TX=2, RX=3.
- `mmio_wr_en` out 1: write strobe.
- `mmio_wr_data` out 8: write data.
- `mmio_rd_data` in 8: combinational read data from the slave. STAT[1]=tx_rdy, STAT[0]=rx_avail.

## Operation
- TX holding register, 1 entry:
  - Loads on `tx_valid && tx_ready`.
  - `tx_ready` = holding register empty.
  - Empties at the end of the S_WRITE cycle.
- RX holding register, 1 entry:
  - Loads `mmio_rd_data` at the end of the S_READ cycle.
  - `rx_valid` = holding register full.
  - Empties on `rx_valid && rx_ready`.
- FSM outputs are Moore, driven from the state register:
  - S_POLL: addr=STAT, wr_en=0. Samples `mmio_rd_data` in the same cycle.
    - `tx_elig` = TX holding register full and tx_rdy.
    - `rx_elig` = rx_avail and RX holding register empty.
    - Only one eligible: go to S_WRITE (TX) or S_READ (RX).
    - Both eligible: round-robin on `last_grant`, granting the side not served last.
    - Neither eligible: stay in S_POLL.
  - S_WRITE: addr=TX, wr_en=1, wr_data=TX holding register. Lasts exactly 1 cycle, then S_GUARD. Sets `last_grant`=TX.
  - S_GUARD: addr=STAT, wr_en=0. Counts `WR_GUARD` cycles, then S_POLL. STAT samples taken during S_GUARD are ignored.
  - S_READ: addr=RX, wr_en=0. Lasts exactly 1 cycle; captures the byte, then S_POLL. Sets `last_grant`=RX.
- Addr=RX is driven only in S_READ, because any RX-address cycle clears the slave's rx_avail. Addr=TX is driven only in S_WRITE.
- `mmio_wr_data` holds its last value outside S_WRITE. It is a don't-care there.
- CTRL is never accessed.

## Timing
- Reset values (asynchronous): state=S_POLL, `mmio_addr`=STAT, `mmio_wr_en`=0, `mmio_wr_data`=0, `tx_ready`=1, `rx_valid`=0, `rx_byte`=0, `last_grant`=RX (so TX wins the first tie), guard counter=0.
- Reset asserted mid-operation: all pending holding data is dropped and a write strobe in flight is cut. No partial state survives.
- TX latency:
  - Byte accepted at edge E0.
  - If STAT shows tx_rdy in cycle E0..E1, `mmio_wr_en` is high in cycle E1..E2.
- Back-to-back TX writes are at least `WR_GUARD`+2 cycles apart: WRITE + GUARD + POLL.
- `tx_ready` reasserts the cycle after S_WRITE. A new byte may be accepted during S_GUARD.
- RX latency:
  - rx_avail is seen in POLL cycle P.
  - S_READ runs in P+1.
  - `rx_valid`=1 from P+2.
- RX holding register full: no RX read is issued. The byte stays in the slave, whose own overrun behaviour applies.
- `rx_valid` and `rx_byte` stay stable while `rx_ready`=0.
- The TX input handshake and an RX output handshake in the same cycle are independent and both complete.

## Structure
- Shared package `uart_mmio_pkg`:
  - Register address constants (CTRL/STAT/TX/RX).
  - STAT bit indices (`STAT_TX_RDY`=1, `STAT_RX_AVAIL`=0).
  - FSM state enum.
  - The slave should import the same constants.
- One natural sub-module: `byte_hold_reg`, a 1-entry valid/ready byte register, instantiated for the TX side. The RX side shares the same load/clear logic inline, because its load is FSM-driven.

## Test plan
- Reset with the slave model at STAT=8'h02: after `rst_n` rises, `mmio_addr`=1, `mmio_wr_en`=0, `tx_ready`=1, `rx_valid`=0.
- TX single byte: send 8'h41 with STAT=8'h02 → `mmio_wr_en` pulses for exactly 1 cycle with addr=2 and data=8'h41, one cycle after acceptance. Then `WR_GUARD` cycles at addr=1.
- TX backpressure: hold STAT=8'h00 for 50 cycles while sending 8'h55 → no write occurs and `tx_ready`=0. STAT→8'h02 produces exactly one write of 8'h55.
- RX path with stall: STAT=8'h01, RX data=8'hA5, `rx_ready`=0 → exactly one addr=3 cycle, then `rx_byte`=8'hA5 is held. A second rx_avail triggers no RX read until the first byte is consumed.
- Contention: TX pending and STAT=8'h03 continuously → the first grant is a TX write, then grants strictly alternate TX/RX.
- Mid-write reset: assert `rst_n`=0 during S_WRITE → `mmio_wr_en` drops asynchronously and the byte is not re-sent after reset.
